// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the MIPS pipeline datapath and pipe_hazard_ctrl.
// The datapath side drives hazard inputs; the hazard unit returns lock/clear/forward/stats.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regW;
  logic              ex_memR;
  logic [REG_AW-1:0] m_rd;
  logic              m_regW;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regW;
  logic              branch_taken;
  logic              mem_ready;
  logic [STAGES-1:0] pipe_lock;
  logic [STAGES-1:0] pipe_clear;
  logic              pc_hold;
  logic [1:0]        forwardA;
  logic [1:0]        forwardB;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;
  logic [CNT_W-1:0]  wait_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd, ex_regW, ex_memR,
           m_rd, m_regW, wb_rd, wb_regW, branch_taken, mem_ready,
    input  pipe_lock, pipe_clear, pc_hold, forwardA, forwardB,
           stall_count, flush_count, wait_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rs, ex_rt, ex_rd, ex_regW, ex_memR,
           m_rd, m_regW, wb_rd, wb_regW, branch_taken, mem_ready,
    output pipe_lock, pipe_clear, pc_hold, forwardA, forwardB,
           stall_count, flush_count, wait_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline-sequencing unit: load-use stalls, branch flush, memory-wait freeze,
// EX-stage forwarding selects and saturating hazard statistics.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES       = 4,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned BRANCH_FLUSH = 3,
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int unsigned RW = $clog2(LOAD_STALL + 1);
  localparam logic [STAGES-1:0] FLUSH_MASK = {STAGES{1'b1}} >> (STAGES - BRANCH_FLUSH);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_e;

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  state_e            eff;
  logic              lu;
  logic              act_stall;
  logic              act_flush;
  logic [STAGES-1:0] lock;
  logic [STAGES-1:0] clear;
  logic              hold;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (hz.m_regW && (hz.m_rd != '0) && (hz.m_rd == src))
      return 2'b10;
    else if (hz.wb_regW && (hz.wb_rd != '0) && (hz.wb_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    lu = hz.ex_memR && hz.ex_regW && (hz.ex_rd != '0) &&
         ((hz.id_use_rs && (hz.ex_rd == hz.id_rs)) ||
          (hz.id_use_rt && (hz.ex_rd == hz.id_rt)));
    // MEMWAIT replays the decision of the state it interrupted.
    eff = (state_q == MEMWAIT) ? saved_q : state_q;

    state_d   = state_q;
    saved_d   = saved_q;
    rem_d     = rem_q;
    act_stall = 1'b0;
    act_flush = 1'b0;
    lock      = '1;
    clear     = '0;
    hold      = 1'b0;

    if (!hz.mem_ready) begin
      lock    = '0;
      hold    = 1'b1;
      state_d = MEMWAIT;
      saved_d = eff;
    end else if (hz.branch_taken) begin
      act_flush = 1'b1;
      clear     = FLUSH_MASK;
      state_d   = RUN;
      rem_d     = '0;
    end else if ((eff == LDSTALL) || lu) begin
      act_stall = 1'b1;
      lock[0]   = 1'b0;
      clear[1]  = 1'b1;
      hold      = 1'b1;
      if (eff == LDSTALL) begin
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == RW'(1)) ? RUN : LDSTALL;
      end else if (LOAD_STALL > 1) begin
        rem_d   = RW'(LOAD_STALL - 1);
        state_d = LDSTALL;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end

    stall_d = (act_stall && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    flush_d = (act_flush && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;
    wait_d  = (!hz.mem_ready && (wait_q != '1)) ? wait_q + 1'b1 : wait_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      rem_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end

  // While reset is low every pipeline register is both enabled and cleared.
  assign hz.pipe_lock   = reset ? lock  : '1;
  assign hz.pipe_clear  = reset ? clear : '1;
  assign hz.pc_hold     = reset ? hold  : 1'b0;
  assign hz.forwardA    = reset ? fwd_sel(hz.ex_rs) : 2'b00;
  assign hz.forwardB    = reset ? fwd_sel(hz.ex_rt) : 2'b00;
  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;
  assign hz.wait_count  = wait_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: two hazard units (LOAD_STALL=1 with 2-bit counters, LOAD_STALL=3) share
// one stimulus stream; expected values are hand-computed per step.
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, m_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_regW, ex_memR, m_regW, wb_regW;
  logic       branch_taken, mem_ready;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_hazard_ctrl_if #(.STAGES(4), .REG_AW(5), .CNT_W(2))  if1 ();
  pipe_hazard_ctrl_if #(.STAGES(4), .REG_AW(5), .CNT_W(16)) if3 ();

  assign if1.id_rs = id_rs;               assign if3.id_rs = id_rs;
  assign if1.id_rt = id_rt;               assign if3.id_rt = id_rt;
  assign if1.id_use_rs = id_use_rs;       assign if3.id_use_rs = id_use_rs;
  assign if1.id_use_rt = id_use_rt;       assign if3.id_use_rt = id_use_rt;
  assign if1.ex_rs = ex_rs;               assign if3.ex_rs = ex_rs;
  assign if1.ex_rt = ex_rt;               assign if3.ex_rt = ex_rt;
  assign if1.ex_rd = ex_rd;               assign if3.ex_rd = ex_rd;
  assign if1.ex_regW = ex_regW;           assign if3.ex_regW = ex_regW;
  assign if1.ex_memR = ex_memR;           assign if3.ex_memR = ex_memR;
  assign if1.m_rd = m_rd;                 assign if3.m_rd = m_rd;
  assign if1.m_regW = m_regW;             assign if3.m_regW = m_regW;
  assign if1.wb_rd = wb_rd;               assign if3.wb_rd = wb_rd;
  assign if1.wb_regW = wb_regW;           assign if3.wb_regW = wb_regW;
  assign if1.branch_taken = branch_taken; assign if3.branch_taken = branch_taken;
  assign if1.mem_ready = mem_ready;       assign if3.mem_ready = mem_ready;

  pipe_hazard_ctrl #(.STAGES(4), .REG_AW(5), .BRANCH_FLUSH(3), .LOAD_STALL(1), .CNT_W(2)) dut1 (
    .clock (clock),
    .reset (reset),
    .hz    (if1)
  );

  pipe_hazard_ctrl #(.STAGES(4), .REG_AW(5), .BRANCH_FLUSH(3), .LOAD_STALL(3), .CNT_W(16)) dut3 (
    .clock (clock),
    .reset (reset),
    .hz    (if3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compares {pipe_lock, pipe_clear, pc_hold} of one unit as a single 9-bit word.
  task automatic ctl(input string tag, input int d, input logic [3:0] lk, input logic [3:0] cl,
                     input logic h);
    logic [8:0] obs;
    obs = (d == 1) ? {if1.pipe_lock, if1.pipe_clear, if1.pc_hold}
                   : {if3.pipe_lock, if3.pipe_clear, if3.pc_hold};
    chk(tag, 32'(obs), 32'({lk, cl, h}));
  endtask

  task automatic cnt(input string tag, input int d, input int s, input int f, input int w);
    if (d == 1) begin
      chk({tag, ".stall1"}, 32'(if1.stall_count), 32'(s));
      chk({tag, ".flush1"}, 32'(if1.flush_count), 32'(f));
      chk({tag, ".wait1"},  32'(if1.wait_count),  32'(w));
    end else begin
      chk({tag, ".stall3"}, 32'(if3.stall_count), 32'(s));
      chk({tag, ".flush3"}, 32'(if3.flush_count), 32'(f));
      chk({tag, ".wait3"},  32'(if3.wait_count),  32'(w));
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_regW = 1'b0; ex_memR = 1'b0;
    m_rd = '0; m_regW = 1'b0; wb_rd = '0; wb_regW = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b1;
  endtask

  // lw $1 in EX, add $2,$1,$3 in ID
  task automatic load_use();
    ex_memR = 1'b1; ex_regW = 1'b1; ex_rd = 5'd1;
    id_rs = 5'd1; id_use_rs = 1'b1; id_rt = 5'd3; id_use_rt = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    ex_rs = 5'd5; m_rd = 5'd5; m_regW = 1'b1;
    @(negedge clock); #1;
    ctl("rst_ctl1", 1, 4'hF, 4'hF, 1'b0);
    ctl("rst_ctl3", 3, 4'hF, 4'hF, 1'b0);
    chk("rst_fwdA", 32'(if1.forwardA), 32'd0);

    @(negedge clock); reset = 1'b1; idle(); #1;
    cnt("rst_cnt", 1, 0, 0, 0);
    cnt("rst_cnt", 3, 0, 0, 0);
    ctl("idle_ctl1", 1, 4'hF, 4'h0, 1'b0);

    // Forwarding
    @(negedge clock); idle();
    ex_rs = 5'd5; ex_rt = 5'd5; m_rd = 5'd5; wb_rd = 5'd5; m_regW = 1'b1; wb_regW = 1'b1; #1;
    chk("fwdA_mem", 32'(if1.forwardA), 32'd2);
    chk("fwdB_mem", 32'(if3.forwardB), 32'd2);
    @(negedge clock); m_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0; #1;
    chk("fwdA_r0", 32'(if1.forwardA), 32'd0);
    @(negedge clock); ex_rs = 5'd5; m_rd = 5'd5; wb_rd = 5'd5; m_regW = 1'b0; ex_rt = 5'd7; #1;
    chk("fwdA_wb", 32'(if1.forwardA), 32'd1);
    chk("fwdB_none", 32'(if1.forwardB), 32'd0);

    // Load-use
    @(negedge clock); idle(); load_use(); #1;
    ctl("lu_ctl1", 1, 4'hE, 4'h2, 1'b1);
    ctl("lu_ctl3", 3, 4'hE, 4'h2, 1'b1);
    @(negedge clock); idle(); id_rs = 5'd1; id_use_rs = 1'b1; id_rt = 5'd3; id_use_rt = 1'b1; #1;
    ctl("lu_after1", 1, 4'hF, 4'h0, 1'b0);
    ctl("lu_bub2_3", 3, 4'hE, 4'h2, 1'b1);
    chk("lu_stall1", 32'(if1.stall_count), 32'd1);
    @(negedge clock); idle(); ex_rs = 5'd1; wb_rd = 5'd1; wb_regW = 1'b1; #1;
    chk("lu_fwdA", 32'(if1.forwardA), 32'd1);
    ctl("lu_run1", 1, 4'hF, 4'h0, 1'b0);
    ctl("lu_bub3_3", 3, 4'hE, 4'h2, 1'b1);
    @(negedge clock); idle(); #1;
    ctl("lu_done3", 3, 4'hF, 4'h0, 1'b0);
    cnt("lu_cnt", 3, 3, 0, 0);
    cnt("lu_cnt", 1, 1, 0, 0);

    // Branch flush, then branch together with load-use
    @(negedge clock); idle(); branch_taken = 1'b1; #1;
    ctl("br_ctl1", 1, 4'hF, 4'h7, 1'b0);
    ctl("br_ctl3", 3, 4'hF, 4'h7, 1'b0);
    @(negedge clock); idle(); #1;
    cnt("br_cnt", 1, 1, 1, 0);
    cnt("br_cnt", 3, 3, 1, 0);
    @(negedge clock); idle(); load_use(); branch_taken = 1'b1; #1;
    ctl("brlu_ctl1", 1, 4'hF, 4'h7, 1'b0);
    ctl("brlu_ctl3", 3, 4'hF, 4'h7, 1'b0);
    @(negedge clock); idle(); #1;
    ctl("brlu_after3", 3, 4'hF, 4'h0, 1'b0);
    cnt("brlu_cnt", 1, 1, 2, 0);
    cnt("brlu_cnt", 3, 3, 2, 0);

    // Memory wait inserted after the first bubble of a 3-cycle stall
    @(negedge clock); idle(); load_use(); #1;
    ctl("mw_lu3", 3, 4'hE, 4'h2, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clock); idle(); mem_ready = 1'b0; #1;
      ctl("mw_hold1", 1, 4'h0, 4'h0, 1'b1);
      ctl("mw_hold3", 3, 4'h0, 4'h0, 1'b1);
    end
    @(negedge clock); idle(); #1;
    ctl("mw_res1_3", 3, 4'hE, 4'h2, 1'b1);
    ctl("mw_res_1", 1, 4'hF, 4'h0, 1'b0);
    @(negedge clock); idle(); #1;
    ctl("mw_res2_3", 3, 4'hE, 4'h2, 1'b1);
    @(negedge clock); idle(); #1;
    ctl("mw_done3", 3, 4'hF, 4'h0, 1'b0);
    cnt("mw_cnt", 3, 6, 2, 4);
    cnt("mw_cnt", 1, 2, 2, 3);

    // Branch held across a memory wait
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge clock); idle(); branch_taken = 1'b1; mem_ready = 1'b0; #1;
      ctl("bw_hold1", 1, 4'h0, 4'h0, 1'b1);
      ctl("bw_hold3", 3, 4'h0, 4'h0, 1'b1);
    end
    @(negedge clock); idle(); branch_taken = 1'b1; #1;
    ctl("bw_flush1", 1, 4'hF, 4'h7, 1'b0);
    ctl("bw_flush3", 3, 4'hF, 4'h7, 1'b0);
    @(negedge clock); idle(); #1;
    ctl("bw_after3", 3, 4'hF, 4'h0, 1'b0);
    cnt("bw_cnt", 1, 2, 3, 3);
    cnt("bw_cnt", 3, 6, 3, 6);

    // Reset in the middle of LDSTALL
    @(negedge clock); idle(); load_use(); #1;
    ctl("rs_lu3", 3, 4'hE, 4'h2, 1'b1);
    @(negedge clock); idle(); reset = 1'b0; #1;
    ctl("rs_low1", 1, 4'hF, 4'hF, 1'b0);
    ctl("rs_low3", 3, 4'hF, 4'hF, 1'b0);
    cnt("rs_pre", 3, 7, 3, 6);
    @(negedge clock); reset = 1'b1; idle(); #1;
    ctl("rs_run3", 3, 4'hF, 4'h0, 1'b0);
    cnt("rs_post", 3, 0, 0, 0);
    cnt("rs_post", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
